ex_mdu_pipe: RTL and testbench
==============================

Name: ex_mdu_pipe

Overview:
Parametrised successor to the combinational execute stage. Registered EX stage that runs the base RV ALU ops in one cycle and adds iterative M-extension multiply/divide.
- valid/ready handshakes on both sides.
- Sits between ID/EX and MEM; stalls upstream via in_ready while a multi-cycle op is in flight or the output is back-pressured.

Parameters:
XLEN, 32, datapath width (≥8, power of two)
ALUSEL_W, 5, width of alusel code
REGADDR_W, 5, width of rd

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
flush  in  1  abort in-flight op and drop output (branch/exception)
in_valid  in  1  operation presented
in_ready  out  1  stage can accept
alusel  in  ALUSEL_W  op code (define.vh)
s1data  in  XLEN  operand 1
s2data  in  XLEN  operand 2
rd  in  REGADDR_W  destination register
regwe  in  1  register write enable
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
rd_o  out  REGADDR_W  registered rd
regwe_o  out  1  registered write enable
result  out  XLEN  registered result

Behaviour:
- Reset (sync, rst=1 at posedge):
  - out_valid=0, rd_o=0, regwe_o=0, result=0.
  - State IDLE, counter=0; in_ready=1 the cycle after.
- Priority: rst > flush > normal.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Combinational; no dependence on in_valid.
- Accept = in_valid && in_ready. rd, regwe and op are latched on accept.
- Output hold: out_valid && !out_ready holds result, rd_o and regwe_o stable. out_valid clears on out_ready unless a new result is loaded in the same edge.
- Single-cycle ops:
  - Codes: AluAdd, AluSub, AluSll, AluSrl, AluSra, AluXor, AluOr, AluAnd, AluUlt, AluSlt.
  - Result registered with out_valid=1 on the edge after accept (latency 1).
  - Shifts use s2data[$clog2(XLEN)-1:0] only; AluSra is arithmetic (sign of s1data).
  - Ult/Slt produce 1 or 0, zero-extended.
- Unknown alusel: result=0, latency 1, regwe_o passed unchanged.
- rd==0 forces regwe_o=0.
- Multiply (AluMul, AluMulh, AluMulhsu, AluMulhu):
  - IDLE→MUL on accept.
  - Operands are converted to magnitudes per signedness; shift-add over XLEN cycles using a 2·XLEN accumulator.
  - Product is sign-corrected in the final cycle. Mul returns the low XLEN bits; the others return the high XLEN bits.
  - out_valid asserts exactly XLEN+1 edges after accept; state→IDLE.
- Divide (AluDiv, AluDivu, AluRem, AluRemu):
  - IDLE→DIV; restoring division over XLEN cycles; latency XLEN+1.
  - Quotient sign = s1 xor s2 (signed ops). Remainder sign = sign of s1.
- Divide special cases are resolved at accept with latency 1, no DIV state:
  - Divisor 0: quotient all-ones, remainder = s1data.
  - Signed overflow (s1 = most-negative, s2 = −1): quotient = s1data, remainder 0.
- Counter: $clog2(XLEN)+1 bits. Loaded 0 on entering MUL/DIV; done at counter==XLEN-1; no wrap beyond.
- flush:
  - Next edge: state→IDLE and out_valid=0.
  - A result being produced on the same edge is discarded.
  - Any input accepted on the flush edge is dropped; in_ready is still computed normally.
- Reset mid-operation: the op is lost, no partial output.

Decomposition:
- define.vh: add AluMul, AluMulh, AluMulhsu, AluMulhu, AluDiv, AluDivu, AluRem, AluRemu codes next to the existing AluAdd..AluSlt. Widen AluSelBus to ALUSEL_W. Add state encodings ExIdle, ExMul, ExDiv.
- Sub-module ex_mdu_iter holds the iterative mul/div datapath: accumulator, counter, sign fix-up.
- The top keeps the single-cycle ALU, handshake and output register.

Test Plan:
- Reset with rst=1 for 2 cycles → out_valid=0, result=0, in_ready=1 after release.
- AluAdd 0x7FFFFFFF+1, then AluSra 0x80000000>>36 → results 0x80000000 then 0xF8000000 (shift uses 4); each out_valid one cycle after accept, back-to-back.
- AluMulh with s1=0xFFFFFFFF (−1), s2=2 → result 0xFFFFFFFF at accept+33; in_ready=0 for those 32 cycles.
- AluDiv 0x80000000 / 0xFFFFFFFF → 0x80000000 with latency 1. AluDivu 7/0 → 0xFFFFFFFF. AluRem −7/2 → 0xFFFFFFFF at accept+33.
- out_ready held 0 for 5 cycles after a result → result, rd_o and regwe_o stable, in_ready=0; released → next op accepted the same cycle.
- AluDivu started, flush at cycle 10 → out_valid never asserts for it, in_ready=1 next cycle; rd=0 with regwe=1 → regwe_o=0.

Source files
------------

// File: rtl/ex_mdu_pipe_pkg.sv
// ex_mdu_pipe_pkg
// Shared definitions for the registered EX stage:
//   - alu_op_e : ALU / M-extension operation codes carried on alusel
//   - ex_state_e : EX stage sequencer states
// Imported by ex_mdu_pipe and ex_mdu_iter.
package ex_mdu_pipe_pkg;

    // Operation codes. Base RV ALU ops first, M-extension ops after them.
    typedef enum logic [4:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SRL    = 5'd3,
        ALU_SRA    = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_OR     = 5'd6,
        ALU_AND    = 5'd7,
        ALU_ULT    = 5'd8,
        ALU_SLT    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    // EX stage sequencer states.
    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_MUL  = 2'd1,
        EX_DIV  = 2'd2
    } ex_state_e;

endpackage

// File: rtl/ex_mdu_iter.sv
// ex_mdu_iter
// Iterative multiply / divide datapath: one shift-add (multiply) or one
// restoring-subtract (divide) step per clock over XLEN clocks, followed by a
// sign fix-up. Operands are reduced to magnitudes at start; the result signs
// are remembered and applied to the finished magnitude.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   clear         : abort any operation in flight (flush)
//   start         : load operands and begin (single-cycle pulse)
//   is_div        : 1 = divide, 0 = multiply
//   a_signed      : treat opa as signed
//   b_signed      : treat opb as signed
//   sel_hi        : multiply: return high half; divide: return remainder
//   opa, opb      : operands (multiplicand/multiplier, dividend/divisor)
//   done          : result valid on res for exactly one cycle
//   res           : sign-corrected result
module ex_mdu_iter
    import ex_mdu_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            start,
    input  logic            is_div,
    input  logic            a_signed,
    input  logic            b_signed,
    input  logic            sel_hi,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            done,
    output logic [XLEN-1:0] res
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    logic [2*XLEN-1:0] acc_r;
    logic [XLEN-1:0]   opb_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              busy_r;
    logic              done_r;
    logic              div_r;
    logic              hi_r;
    logic              neg_main_r;
    logic              neg_rem_r;

    logic              a_neg_s;
    logic              b_neg_s;
    logic [XLEN-1:0]   mag_a_s;
    logic [XLEN-1:0]   mag_b_s;
    logic [XLEN:0]     sum_s;
    logic [XLEN:0]     rem_ext_s;
    logic [XLEN:0]     diff_s;
    logic [2*XLEN-1:0] step_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s;
    logic [XLEN-1:0]   rem_s;

    // Operand magnitudes and signs at start time.
    always_comb begin
        a_neg_s = a_signed & opa[XLEN-1];
        b_neg_s = b_signed & opb[XLEN-1];
        mag_a_s = a_neg_s ? (~opa + {{(XLEN-1){1'b0}}, 1'b1}) : opa;
        mag_b_s = b_neg_s ? (~opb + {{(XLEN-1){1'b0}}, 1'b1}) : opb;
    end

    // One iteration step. Multiply: add multiplicand into the high half when
    // the current multiplier bit is set, then shift the pair right, keeping
    // the carry. Divide: shift the remainder/quotient pair left and subtract
    // the divisor when it fits (top bit of the difference is the borrow).
    always_comb begin
        sum_s     = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
        rem_ext_s = acc_r[2*XLEN-1:XLEN-1];
        diff_s    = rem_ext_s - {1'b0, opb_r};
        if (div_r) begin
            if (diff_s[XLEN]) begin
                step_s = {rem_ext_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
            end else begin
                step_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
            end
        end else begin
            step_s = {sum_s, acc_r[XLEN-1:1]};
        end
    end

    // Final sign fix-up and result selection from the finished accumulator.
    always_comb begin
        prod_s = neg_main_r ? (~acc_r + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_r;
        quo_s  = neg_main_r ? (~acc_r[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1}) : acc_r[XLEN-1:0];
        rem_s  = neg_rem_r ? (~acc_r[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1}) : acc_r[2*XLEN-1:XLEN];
        if (div_r) begin
            res = hi_r ? rem_s : quo_s;
        end else begin
            res = hi_r ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
        end
    end

    assign done = done_r;

    // Iteration sequencing: load on start, step while busy, flag done once.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc_r      <= {(2*XLEN){1'b0}};
            opb_r      <= {XLEN{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            div_r      <= 1'b0;
            hi_r       <= 1'b0;
            neg_main_r <= 1'b0;
            neg_rem_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                acc_r      <= {{XLEN{1'b0}}, mag_a_s};
                opb_r      <= mag_b_s;
                cnt_r      <= {CNT_W{1'b0}};
                busy_r     <= 1'b1;
                div_r      <= is_div;
                hi_r       <= sel_hi;
                neg_main_r <= a_neg_s ^ b_neg_s;
                neg_rem_r  <= a_neg_s;
            end else if (busy_r) begin
                acc_r <= step_s;
                if (cnt_r == CNT_W'(XLEN - 1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    end

endmodule

// File: rtl/ex_mdu_pipe.sv
// ex_mdu_pipe
// Registered EX stage. Base ALU ops and divide special cases complete with
// latency 1; multiply and regular divide run on ex_mdu_iter and complete
// XLEN+1 clocks after accept. valid/ready handshake on both sides.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   flush                : abort in-flight op, drop output
//   in_valid / in_ready  : upstream handshake
//   alusel               : operation code (alu_op_e)
//   s1data, s2data       : operands
//   rd, regwe            : destination register and write enable
//   out_valid / out_ready: downstream handshake
//   rd_o, regwe_o, result: registered outputs
module ex_mdu_pipe
    import ex_mdu_pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ALUSEL_W  = 5,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ALUSEL_W-1:0]  alusel,
    input  logic [XLEN-1:0]      s1data,
    input  logic [XLEN-1:0]      s2data,
    input  logic [REGADDR_W-1:0] rd,
    input  logic                 regwe,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [REGADDR_W-1:0] rd_o,
    output logic                 regwe_o,
    output logic [XLEN-1:0]      result
);

    localparam int SH_W = $clog2(XLEN);

    ex_state_e            state_r;
    logic [REGADDR_W-1:0] rd_lat_r;
    logic                 regwe_lat_r;

    logic [XLEN-1:0]      alu_res_s;
    logic                 is_mul_s;
    logic                 is_div_s;
    logic                 a_sg_s;
    logic                 b_sg_s;
    logic                 sel_hi_s;
    logic                 div_zero_s;
    logic                 div_ovf_s;
    logic                 special_s;
    logic                 multi_s;
    logic                 accept_s;
    logic                 wen_s;
    logic                 iter_start_s;
    logic                 iter_done_s;
    logic [XLEN-1:0]      iter_res_s;
    logic [SH_W-1:0]      shamt_s;

    assign in_ready     = (state_r == EX_IDLE) && (!out_valid || out_ready);
    assign accept_s     = in_valid && in_ready;
    assign wen_s        = regwe && (rd != {REGADDR_W{1'b0}});
    assign iter_start_s = accept_s && multi_s && !flush && !rst;

    // Single-cycle ALU and mul/div decode, including divide special cases.
    always_comb begin
        alu_res_s  = {XLEN{1'b0}};
        is_mul_s   = 1'b0;
        is_div_s   = 1'b0;
        a_sg_s     = 1'b0;
        b_sg_s     = 1'b0;
        sel_hi_s   = 1'b0;
        shamt_s    = s2data[SH_W-1:0];
        div_zero_s = (s2data == {XLEN{1'b0}});
        div_ovf_s  = (s1data == {1'b1, {(XLEN-1){1'b0}}}) && (s2data == {XLEN{1'b1}});
        case (alusel)
            ALUSEL_W'(ALU_ADD): alu_res_s = s1data + s2data;
            ALUSEL_W'(ALU_SUB): alu_res_s = s1data - s2data;
            ALUSEL_W'(ALU_SLL): alu_res_s = s1data << shamt_s;
            ALUSEL_W'(ALU_SRL): alu_res_s = s1data >> shamt_s;
            ALUSEL_W'(ALU_SRA): alu_res_s = $unsigned($signed(s1data) >>> shamt_s);
            ALUSEL_W'(ALU_XOR): alu_res_s = s1data ^ s2data;
            ALUSEL_W'(ALU_OR):  alu_res_s = s1data | s2data;
            ALUSEL_W'(ALU_AND): alu_res_s = s1data & s2data;
            ALUSEL_W'(ALU_ULT): alu_res_s = {{(XLEN-1){1'b0}}, (s1data < s2data)};
            ALUSEL_W'(ALU_SLT): alu_res_s = {{(XLEN-1){1'b0}}, ($signed(s1data) < $signed(s2data))};
            ALUSEL_W'(ALU_MUL): begin
                is_mul_s = 1'b1;
            end
            ALUSEL_W'(ALU_MULH): begin
                is_mul_s = 1'b1;
                a_sg_s   = 1'b1;
                b_sg_s   = 1'b1;
                sel_hi_s = 1'b1;
            end
            ALUSEL_W'(ALU_MULHSU): begin
                is_mul_s = 1'b1;
                a_sg_s   = 1'b1;
                sel_hi_s = 1'b1;
            end
            ALUSEL_W'(ALU_MULHU): begin
                is_mul_s = 1'b1;
                sel_hi_s = 1'b1;
            end
            ALUSEL_W'(ALU_DIV): begin
                is_div_s  = 1'b1;
                a_sg_s    = 1'b1;
                b_sg_s    = 1'b1;
                alu_res_s = div_zero_s ? {XLEN{1'b1}} : s1data;
            end
            ALUSEL_W'(ALU_DIVU): begin
                is_div_s  = 1'b1;
                alu_res_s = {XLEN{1'b1}};
            end
            ALUSEL_W'(ALU_REM): begin
                is_div_s  = 1'b1;
                a_sg_s    = 1'b1;
                b_sg_s    = 1'b1;
                sel_hi_s  = 1'b1;
                alu_res_s = div_zero_s ? s1data : {XLEN{1'b0}};
            end
            ALUSEL_W'(ALU_REMU): begin
                is_div_s  = 1'b1;
                sel_hi_s  = 1'b1;
                alu_res_s = s1data;
            end
            default: alu_res_s = {XLEN{1'b0}};
        endcase
        // Divide-by-zero and signed overflow bypass the iterator; alu_res_s
        // already holds their answers (only valid when special_s is set).
        special_s = is_div_s && (div_zero_s || (a_sg_s && div_ovf_s));
        multi_s   = is_mul_s || (is_div_s && !special_s);
    end

    ex_mdu_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .start    (iter_start_s),
        .is_div   (is_div_s),
        .a_signed (a_sg_s),
        .b_signed (b_sg_s),
        .sel_hi   (sel_hi_s),
        .opa      (s1data),
        .opb      (s2data),
        .done     (iter_done_s),
        .res      (iter_res_s)
    );

    // Sequencer and output register: rst > flush > normal operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= EX_IDLE;
            out_valid   <= 1'b0;
            rd_o        <= {REGADDR_W{1'b0}};
            regwe_o     <= 1'b0;
            result      <= {XLEN{1'b0}};
            rd_lat_r    <= {REGADDR_W{1'b0}};
            regwe_lat_r <= 1'b0;
        end else if (flush) begin
            state_r   <= EX_IDLE;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state_r)
                EX_IDLE: begin
                    if (accept_s) begin
                        if (multi_s) begin
                            rd_lat_r    <= rd;
                            regwe_lat_r <= wen_s;
                            state_r     <= is_mul_s ? EX_MUL : EX_DIV;
                        end else begin
                            result    <= alu_res_s;
                            rd_o      <= rd;
                            regwe_o   <= wen_s;
                            out_valid <= 1'b1;
                        end
                    end
                end
                EX_MUL, EX_DIV: begin
                    // out_valid is already clear here: accept required the
                    // previous result to be consumed on the accept edge.
                    if (iter_done_s) begin
                        result    <= iter_res_s;
                        rd_o      <= rd_lat_r;
                        regwe_o   <= regwe_lat_r;
                        out_valid <= 1'b1;
                        state_r   <= EX_IDLE;
                    end
                end
                default: state_r <= EX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_mdu_pipe.sv
module tb_ex_mdu_pipe;
    import ex_mdu_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  alusel = 5'd0;
    logic [31:0] s1data = 32'd0;
    logic [31:0] s2data = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        regwe = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  rd_o;
    logic        regwe_o;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ex_mdu_pipe #(.XLEN(32), .ALUSEL_W(5), .REGADDR_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alusel    (alusel),
        .s1data    (s1data),
        .s2data    (s2data),
        .rd        (rd),
        .regwe     (regwe),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd_o      (rd_o),
        .regwe_o   (regwe_o),
        .result    (result)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rdv;
        logic        we;
        logic [31:0] exp_res;
        logic        exp_we;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic w);
        in_valid = 1'b1;
        alusel   = op;
        s1data   = a;
        s2data   = b;
        rd       = r;
        regwe    = w;
    endtask

    // Accept one multi-cycle op, measure latency, check stall and result.
    task automatic run_multi(input string name, input logic [4:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        int n;
        int stall_err;
        drive(op, a, b, 5'd7, 1'b1);
        check({name, "_rdy"}, 32'(in_ready), 32'd1);
        tick();
        in_valid  = 1'b0;
        n         = 0;
        stall_err = 0;
        while (!out_valid && n < 100) begin
            if (in_ready) stall_err++;
            tick();
            n++;
        end
        check({name, "_lat"}, 32'(n), 32'd33);
        check({name, "_res"}, result, exp);
        check({name, "_rd"}, 32'(rd_o), 32'd7);
        check({name, "_stall"}, 32'(stall_err), 32'd0);
        tick();
        check({name, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int errs;
        vecs[0]  = '{ALU_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd1,  1'b1, 32'h80000000, 1'b1};
        vecs[1]  = '{ALU_SRA,  32'h80000000, 32'h00000024, 5'd2,  1'b1, 32'hF8000000, 1'b1};
        vecs[2]  = '{ALU_SUB,  32'h00000005, 32'h00000007, 5'd3,  1'b1, 32'hFFFFFFFE, 1'b1};
        vecs[3]  = '{ALU_SLL,  32'h00000001, 32'h0000003F, 5'd4,  1'b1, 32'h80000000, 1'b1};
        vecs[4]  = '{ALU_SRL,  32'h80000000, 32'h00000024, 5'd5,  1'b0, 32'h08000000, 1'b0};
        vecs[5]  = '{ALU_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd6,  1'b1, 32'h0FF00FF0, 1'b1};
        vecs[6]  = '{ALU_OR,   32'h0F000000, 32'h000000F0, 5'd7,  1'b1, 32'h0F0000F0, 1'b1};
        vecs[7]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd8,  1'b1, 32'hF000F000, 1'b1};
        vecs[8]  = '{ALU_ULT,  32'h00000001, 32'hFFFFFFFF, 5'd9,  1'b1, 32'h00000001, 1'b1};
        vecs[9]  = '{ALU_SLT,  32'h00000001, 32'hFFFFFFFF, 5'd10, 1'b1, 32'h00000000, 1'b1};
        vecs[10] = '{ALU_SLT,  32'h80000000, 32'h00000000, 5'd11, 1'b1, 32'h00000001, 1'b1};
        vecs[11] = '{ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd12, 1'b1, 32'h80000000, 1'b1};
        vecs[12] = '{ALU_REM,  32'h80000000, 32'hFFFFFFFF, 5'd13, 1'b1, 32'h00000000, 1'b1};
        vecs[13] = '{ALU_DIVU, 32'h00000007, 32'h00000000, 5'd14, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[14] = '{ALU_REMU, 32'h00000007, 32'h00000000, 5'd15, 1'b1, 32'h00000007, 1'b1};
        vecs[15] = '{ALU_DIV,  32'hFFFFFFFB, 32'h00000000, 5'd16, 1'b1, 32'hFFFFFFFF, 1'b1};
        vecs[16] = '{5'd31,    32'h12345678, 32'h11111111, 5'd17, 1'b1, 32'h00000000, 1'b1};
        vecs[17] = '{ALU_ADD,  32'h00000001, 32'h00000002, 5'd0,  1'b1, 32'h00000003, 1'b0};

        // Reset held for two cycles.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", 32'(rd_o), 32'd0);
        check("rst_we", 32'(regwe_o), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        // Back-to-back single-cycle ops and divide special cases.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rdv, vecs[i].we);
            check($sformatf("v%0d_rdy", i), 32'(in_ready), 32'd1);
            tick();
            check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d_res", i), result, vecs[i].exp_res);
            check($sformatf("v%0d_rd", i), 32'(rd_o), 32'(vecs[i].rdv));
            check($sformatf("v%0d_we", i), 32'(regwe_o), 32'(vecs[i].exp_we));
        end
        in_valid = 1'b0;
        tick();
        check("tbl_drain", 32'(out_valid), 32'd0);

        // Iterative ops.
        run_multi("mulh",   ALU_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
        run_multi("mul",    ALU_MUL,    32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF);
        run_multi("mulhu",  ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_multi("mulhsu", ALU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_multi("rem",    ALU_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
        run_multi("div",    ALU_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
        run_multi("divu",   ALU_DIVU,   32'd100,      32'd7,        32'd14);
        run_multi("remu",   ALU_REMU,   32'd100,      32'd7,        32'd2);

        // Output back-pressure for 5 cycles.
        out_ready = 1'b0;
        drive(ALU_ADD, 32'd2, 32'd3, 5'd9, 1'b1);
        tick();
        in_valid = 1'b0;
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_res", result, 32'd5);
        errs = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (result !== 32'd5 || rd_o !== 5'd9 || regwe_o !== 1'b1 ||
                in_ready !== 1'b0 || out_valid !== 1'b1) errs++;
        end
        check("bp_hold", 32'(errs), 32'd0);
        out_ready = 1'b1;
        drive(ALU_SUB, 32'd10, 32'd4, 5'd3, 1'b1);
        #1;
        check("bp_release_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_res", result, 32'd6);
        check("bp_next_rd", 32'(rd_o), 32'd3);
        tick();
        check("bp_drain", 32'(out_valid), 32'd0);

        // Flush an in-flight divide.
        drive(ALU_DIVU, 32'd1000, 32'd3, 5'd4, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_valid", 32'(out_valid), 32'd0);
        check("fl_ready", 32'(in_ready), 32'd1);
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (out_valid) errs++;
        end
        check("fl_no_out", 32'(errs), 32'd0);

        // Input presented on a flush edge is dropped.
        drive(ALU_ADD, 32'd1, 32'd1, 5'd5, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_drop_valid", 32'(out_valid), 32'd0);
        check("fl_drop_rdy", 32'(in_ready), 32'd1);
        tick();
        check("fl_drop_later", 32'(out_valid), 32'd0);

        // Stage still works after flush.
        drive(ALU_ADD, 32'd1, 32'd1, 5'd5, 1'b1);
        tick();
        in_valid = 1'b0;
        check("post_fl_res", result, 32'd2);
        check("post_fl_valid", 32'(out_valid), 32'd1);
        tick();

        // Reset in the middle of a multiply.
        drive(ALU_MUL, 32'd3, 32'd5, 5'd6, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        errs = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) errs++;
            tick();
        end
        check("rst_mid_no_out", 32'(errs), 32'd0);
        check("rst_mid_res", result, 32'd0);
        check("rst_mid_rdy", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
